// File: rtl/conv_encoder_tx.sv
// Rate-1/2 feedforward convolutional encoder with a valid/ready input, a single registered
// output slot, and K-1 zero tail bits after every FRAME_LEN info bits.
module conv_encoder_tx #(
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter int             FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  input  logic       in_bit_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [1:0] out_sym_o,
  output logic       out_last_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic       frame_done_o
);

  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int TAIL_W = $clog2(K);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [TAIL_W-1:0] LAST_TAIL = TAIL_W'(K - 2);

  typedef enum logic {DATA, TAIL} state_t;

  state_t            state;
  logic [K-2:0]      sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TAIL_W-1:0] tail_cnt;

  logic       slot_free;
  logic       accept;
  logic       tail_step;
  logic       encode_en;
  logic       u;
  logic [1:0] sym_next;

  // v = {u, sr[0], ..., sr[K-2]}: the newest past bit sits just below u.
  function automatic logic [1:0] encode(input logic bit_u, input logic [K-2:0] s);
    logic [K-1:0] v;
    v[K-1] = bit_u;
    for (int i = 0; i < K - 1; i++) begin
      v[K-2-i] = s[i];
    end
    return {^(G0 & v), ^(G1 & v)};
  endfunction

  function automatic logic [K-2:0] shift_in(input logic [K-2:0] s, input logic bit_u);
    logic [K-1:0] t;
    t = {s, bit_u};
    return t[K-2:0];
  endfunction

  assign slot_free  = !out_valid_o || out_ready_i;
  assign in_ready_o = (state == DATA) && slot_free;
  assign accept     = in_valid_i && in_ready_o;
  assign tail_step  = (state == TAIL) && slot_free;
  assign encode_en  = accept || tail_step;
  assign u          = (state == DATA) && in_bit_i;
  assign sym_next   = encode(u, sr);
  assign busy_o     = (state == TAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= DATA;
      sr           <= '0;
      bit_cnt      <= '0;
      tail_cnt     <= '0;
      out_valid_o  <= 1'b0;
      out_sym_o    <= 2'b00;
      out_last_o   <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= out_valid_o && out_ready_i && out_last_o;

      // Output slot: reloads only when empty or draining this cycle; otherwise frozen.
      if (slot_free) begin
        out_valid_o <= encode_en;
        out_last_o  <= tail_step && (tail_cnt == LAST_TAIL);
        if (encode_en) begin
          out_sym_o <= sym_next;
        end
      end

      if (encode_en) begin
        sr <= shift_in(sr, u);
      end

      case (state)
        DATA: begin
          if (accept) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt  <= '0;
              tail_cnt <= '0;
              state    <= TAIL;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        TAIL: begin
          if (slot_free) begin
            if (tail_cnt == LAST_TAIL) begin
              tail_cnt <= '0;
              state    <= DATA;
            end else begin
              tail_cnt <= tail_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Directed bench for conv_encoder_tx: a FRAME_LEN=4 instance for hand-computed frames and a
// FRAME_LEN=16 instance for streaming and randomised-handshake runs against a reference model.
module tb_conv_encoder_tx;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_in_valid, a_in_bit, a_in_ready, a_out_valid, a_out_last, a_out_ready;
  logic       a_busy, a_frame_done;
  logic [1:0] a_out_sym;
  logic       b_in_valid, b_in_bit, b_in_ready, b_out_valid, b_out_last, b_out_ready;
  logic       b_busy, b_frame_done;
  logic [1:0] b_out_sym;

  int checks   = 0;
  int failures = 0;

  logic       acc_q[$];
  logic [2:0] obs_q[$];
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  conv_encoder_tx #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(a_in_valid), .in_bit_i(a_in_bit), .in_ready_o(a_in_ready),
    .out_valid_o(a_out_valid), .out_sym_o(a_out_sym), .out_last_o(a_out_last),
    .out_ready_i(a_out_ready), .busy_o(a_busy), .frame_done_o(a_frame_done)
  );

  conv_encoder_tx #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(b_in_valid), .in_bit_i(b_in_bit), .in_ready_o(b_in_ready),
    .out_valid_o(b_out_valid), .out_sym_o(b_out_sym), .out_last_o(b_out_last),
    .out_ready_i(b_out_ready), .busy_o(b_busy), .frame_done_o(b_frame_done)
  );

  // Drives one 4-bit frame into dut_a and records every transferred symbol (first symbol ends
  // up most significant in sym_flat/lasts). Optional stall holds out_ready low once the first
  // symbol appears; stall_bad counts stall cycles where the slot moved or in_ready was high.
  task automatic collect4(input logic [3:0] bits, input int stall_len,
                          output logic [15:0] sym_flat, output logic [7:0] lasts,
                          output int nsym, output int fd_cnt, output int fd_gap,
                          output int rdy_low, output int stall_bad);
    int bi = 0;
    int stall_left = 0;
    int last_cyc = -100;
    logic stalled_once = 1'b0;
    logic [1:0] held = 2'b00;
    sym_flat = '0; lasts = '0; nsym = 0; fd_cnt = 0; fd_gap = -1; rdy_low = 0; stall_bad = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (stall_len > 0 && !stalled_once && a_out_valid === 1'b1) begin
        stalled_once = 1'b1;
        stall_left   = stall_len;
        held         = a_out_sym;
      end
      a_out_ready = (stall_left == 0);
      a_in_valid  = (bi < 4);
      a_in_bit    = (bi < 4) ? bits[3-bi] : 1'b0;
      #1;
      if (stall_left > 0) begin
        if (a_out_valid !== 1'b1 || a_out_sym !== held || a_in_ready !== 1'b0) stall_bad++;
        stall_left--;
      end
      if (a_in_ready !== 1'b1) rdy_low++;
      if (a_frame_done === 1'b1) begin
        fd_cnt++;
        fd_gap = cyc - last_cyc;
      end
      if (a_in_valid && a_in_ready) bi++;
      if (a_out_valid && a_out_ready) begin
        sym_flat = {sym_flat[13:0], a_out_sym};
        lasts    = {lasts[6:0], a_out_last};
        nsym++;
        if (a_out_last) last_cyc = cyc;
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
  endtask

  // Runs dut_b until target symbols have transferred (plus two cycles for frame_done) or the
  // cycle budget expires; records accepted bits and transferred {last,sym} into queues.
  task automatic run_b(input int nbits, input bit rnd, input int max_cycles,
                       output int rdy_low, output int fd, output int stable_bad,
                       output int first_xfer, output int last_xfer);
    int bi = 0;
    int after = 0;
    int target;
    logic prev_stall = 1'b0;
    logic [1:0] prev_sym = 2'b00;
    logic prev_last = 1'b0;
    target = (nbits / 16) * 18;
    rdy_low = 0; fd = 0; stable_bad = 0; first_xfer = -1; last_xfer = -1;
    acc_q.delete();
    obs_q.delete();
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      b_in_valid  = (bi < nbits) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      b_in_bit    = 1'($urandom_range(0, 1));
      b_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && (b_out_valid !== 1'b1 || b_out_sym !== prev_sym || b_out_last !== prev_last))
        stable_bad++;
      prev_stall = b_out_valid && !b_out_ready;
      prev_sym   = b_out_sym;
      prev_last  = b_out_last;
      if (b_in_ready !== 1'b1) rdy_low++;
      if (b_frame_done === 1'b1) fd++;
      if (b_in_valid && b_in_ready) begin
        acc_q.push_back(b_in_bit);
        bi++;
      end
      if (b_out_valid && b_out_ready) begin
        obs_q.push_back({b_out_last, b_out_sym});
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      if (obs_q.size() >= target) after++;
      if (after > 2) break;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
  endtask

  // Reference: c0 = u ^ prev1 ^ prev2, c1 = u ^ prev2, two zero tails after every 16 bits.
  task automatic build_exp();
    logic s1 = 1'b0;
    logic s2 = 1'b0;
    int n = 0;
    exp_q.delete();
    foreach (acc_q[i]) begin
      exp_q.push_back({1'b0, acc_q[i] ^ s1 ^ s2, acc_q[i] ^ s2});
      s2 = s1; s1 = acc_q[i]; n++;
      if (n == 16) begin
        for (int t = 0; t < 2; t++) begin
          exp_q.push_back({(t == 1), s1 ^ s2, s2});
          s2 = s1; s1 = 1'b0;
        end
        n = 0;
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] sf; logic [7:0] ls;
    int ns, fc, fg, rl, sb;
    int bi = 0;
    logic found = 1'b0;
    logic [3:0] pre = 4'b1011;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL por_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_sym !== 2'b00) begin failures++; $display("FAIL por_sym got=%b exp=00", a_out_sym); end
    checks++; if (a_out_last !== 1'b0) begin failures++; $display("FAIL por_last got=%b exp=0", a_out_last); end
    checks++; if (a_frame_done !== 1'b0) begin failures++; $display("FAIL por_done got=%b exp=0", a_frame_done); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL por_busy got=%b exp=0", a_busy); end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      a_out_ready = 1'b1;
      a_in_valid  = (bi < 4);
      a_in_bit    = (bi < 4) ? pre[3-bi] : 1'b0;
      #1;
      if (a_busy === 1'b1) found = 1'b1;
      else if (a_in_valid && a_in_ready) bi++;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL reach_tail got=%b exp=1", found); end
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_sym !== 2'b00) begin failures++; $display("FAIL rst_sym got=%b exp=00", a_out_sym); end
    checks++; if (a_out_last !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", a_out_last); end
    checks++; if (a_frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", a_frame_done); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    collect4(4'b1000, 0, sf, ls, ns, fc, fg, rl, sb);
    checks++; if (ns !== 6) begin failures++; $display("FAIL rst_nsym got=%0d exp=6", ns); end
    checks++; if (sf[11:0] !== 12'b11_10_11_00_00_00) begin failures++; $display("FAIL rst_syms got=%b exp=111011000000", sf[11:0]); end
    checks++; if (ls[5:0] !== 6'b000001) begin failures++; $display("FAIL rst_lasts got=%b exp=000001", ls[5:0]); end
  endtask

  task automatic test_impulse();
    logic [15:0] sf; logic [7:0] ls;
    int ns, fc, fg, rl, sb;
    collect4(4'b1000, 0, sf, ls, ns, fc, fg, rl, sb);
    checks++; if (ns !== 6) begin failures++; $display("FAIL imp_nsym got=%0d exp=6", ns); end
    checks++; if (sf[11:0] !== 12'b11_10_11_00_00_00) begin failures++; $display("FAIL imp_syms got=%b exp=111011000000", sf[11:0]); end
    checks++; if (ls[5:0] !== 6'b000001) begin failures++; $display("FAIL imp_lasts got=%b exp=000001", ls[5:0]); end
    checks++; if (fc !== 1) begin failures++; $display("FAIL imp_done_cnt got=%0d exp=1", fc); end
    checks++; if (fg !== 1) begin failures++; $display("FAIL imp_done_gap got=%0d exp=1", fg); end
  endtask

  task automatic test_known_vector();
    logic [15:0] sf; logic [7:0] ls;
    int ns, fc, fg, rl, sb;
    collect4(4'b1011, 0, sf, ls, ns, fc, fg, rl, sb);
    checks++; if (ns !== 6) begin failures++; $display("FAIL kv_nsym got=%0d exp=6", ns); end
    checks++; if (sf[11:0] !== 12'b11_10_00_01_01_11) begin failures++; $display("FAIL kv_syms got=%b exp=111000010111", sf[11:0]); end
    checks++; if (ls[5:0] !== 6'b000001) begin failures++; $display("FAIL kv_lasts got=%b exp=000001", ls[5:0]); end
    checks++; if (rl !== 2) begin failures++; $display("FAIL kv_ready_low got=%0d exp=2", rl); end
    checks++; if (fc !== 1) begin failures++; $display("FAIL kv_done_cnt got=%0d exp=1", fc); end
  endtask

  task automatic test_backpressure();
    logic [15:0] sf; logic [7:0] ls;
    int ns, fc, fg, rl, sb;
    collect4(4'b1011, 5, sf, ls, ns, fc, fg, rl, sb);
    checks++; if (sb !== 0) begin failures++; $display("FAIL bp_stall_bad got=%0d exp=0", sb); end
    checks++; if (ns !== 6) begin failures++; $display("FAIL bp_nsym got=%0d exp=6", ns); end
    checks++; if (sf[11:0] !== 12'b11_10_00_01_01_11) begin failures++; $display("FAIL bp_syms got=%b exp=111000010111", sf[11:0]); end
    checks++; if (ls[5:0] !== 6'b000001) begin failures++; $display("FAIL bp_lasts got=%b exp=000001", ls[5:0]); end
    checks++; if (rl !== 7) begin failures++; $display("FAIL bp_ready_low got=%0d exp=7", rl); end
    checks++; if (fc !== 1) begin failures++; $display("FAIL bp_done_cnt got=%0d exp=1", fc); end
  endtask

  task automatic test_streaming();
    int rl, fd, sb, fx, lx;
    run_b(48, 1'b0, 200, rl, fd, sb, fx, lx);
    build_exp();
    checks++; if (acc_q.size() !== 48) begin failures++; $display("FAIL st_bits got=%0d exp=48", acc_q.size()); end
    checks++; if (obs_q.size() !== 54) begin failures++; $display("FAIL st_nsym got=%0d exp=54", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL st_sym[%0d] got=%b exp=%b", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (fx !== 1) begin failures++; $display("FAIL st_first_xfer got=%0d exp=1", fx); end
    checks++; if (lx !== 54) begin failures++; $display("FAIL st_last_xfer got=%0d exp=54", lx); end
    checks++; if (rl !== 6) begin failures++; $display("FAIL st_ready_low got=%0d exp=6", rl); end
    checks++; if (fd !== 3) begin failures++; $display("FAIL st_done_cnt got=%0d exp=3", fd); end
  endtask

  task automatic test_bubbles();
    int rl, fd, sb, fx, lx;
    run_b(48, 1'b1, 1500, rl, fd, sb, fx, lx);
    build_exp();
    checks++; if (acc_q.size() !== 48) begin failures++; $display("FAIL bub_bits got=%0d exp=48", acc_q.size()); end
    checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL bub_nsym got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bub_sym[%0d] got=%b exp=%b", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (sb !== 0) begin failures++; $display("FAIL bub_stable got=%0d exp=0", sb); end
    checks++; if (fd !== 3) begin failures++; $display("FAIL bub_done_cnt got=%0d exp=3", fd); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_bit = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_bit = 1'b0; b_out_ready = 1'b1;
    test_reset();
    test_impulse();
    test_known_vector();
    test_backpressure();
    test_streaming();
    test_bubbles();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
